// File: rtl/cnn_pkg.sv
// Shared constants, pixel type and window indexing helper for the CNN front end.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int K          = 3;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // Flat element index of window position (r,c); r=0 is the oldest row, c=0 the leftmost column.
  function automatic int win_idx(input int r, input int c, input int k = K);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: a DEPTH-long shift chain advanced on every accepted pixel.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] taps_r [DEPTH];

  // Shift the chain by one position whenever a pixel is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_r[i] <= '0;
      end
    end else if (ce) begin
      taps_r[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        taps_r[i] <= taps_r[i-1];
      end
    end
  end

  assign data_out = taps_r[DEPTH-1];

endmodule

// File: rtl/window_generator.sv
// Sliding KxK window generator over a row-major pixel stream, with line buffers
// providing the rows above the current one.
module window_generator #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int K          = cnn_pkg::K,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [K*K*DATA_WIDTH-1:0] win,
  output logic                      out_valid,
  output logic                      frame_done
);

  import cnn_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]             col_r;
  logic [RW-1:0]             row_r;
  logic                      accept_s;
  logic                      last_col_s;
  logic                      last_row_s;
  logic                      in_win_s;
  logic [DATA_WIDTH-1:0]     lb_in_s  [K-1];
  logic [DATA_WIDTH-1:0]     lb_out_s [K-1];
  logic [DATA_WIDTH-1:0]     col_s    [K];
  logic [K*K*DATA_WIDTH-1:0] win_r;
  logic [K*K*DATA_WIDTH-1:0] win_nxt_s;
  logic                      out_valid_r;
  logic                      frame_done_r;

  assign accept_s   = ce & in_valid;
  assign last_col_s = (col_r == CW'(IMG_W - 1));
  assign last_row_s = (row_r == RW'(IMG_H - 1));
  assign in_win_s   = (row_r >= RW'(K - 1)) && (col_r >= CW'(K - 1));

  // Chain of K-1 line buffers: buffer 0 takes the live pixel, each later one the previous output.
  for (genvar n = 0; n < K - 1; n++) begin : g_lb
    if (n == 0) begin : g_first
      assign lb_in_s[n] = data_in;
    end else begin : g_next
      assign lb_in_s[n] = lb_out_s[n-1];
    end
    line_buffer #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (IMG_W)
    ) u_lb (
      .clk      (clk),
      .rst      (rst),
      .ce       (accept_s),
      .data_in  (lb_in_s[n]),
      .data_out (lb_out_s[n])
    );
  end

  // New right-hand column, oldest row at the top, live pixel at the bottom.
  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_live
      assign col_s[r] = data_in;
    end else begin : g_buf
      assign col_s[r] = lb_out_s[K-2-r];
    end
  end

  // Next window: every column moves one step left, the new column enters on the right.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_elem
      localparam int DST = win_idx(r, c, K);
      if (c < K - 1) begin : g_shift
        localparam int SRC = win_idx(r, c + 1, K);
        assign win_nxt_s[DST*DATA_WIDTH +: DATA_WIDTH] = win_r[SRC*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_new
        assign win_nxt_s[DST*DATA_WIDTH +: DATA_WIDTH] = col_s[r];
      end
    end
  end

  // Position of the next pixel to be accepted, wrapping at line and frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (last_col_s) begin
        col_r <= '0;
        row_r <= last_row_s ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Window register and status flags; idle enabled cycles drop the flags, ce=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r        <= '0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (ce) begin
      if (in_valid) begin
        win_r        <= win_nxt_s;
        out_valid_r  <= in_win_s;
        frame_done_r <= last_col_s & last_row_s;
      end else begin
        out_valid_r  <= 1'b0;
        frame_done_r <= 1'b0;
      end
    end
  end

  assign win        = win_r;
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator (K=3, 8x6 image) against an image-array model.
module tb_window_generator;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WB = K * K * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          in_valid;
  logic [DW-1:0] data_in;
  logic [WB-1:0] win;
  logic          out_valid;
  logic          frame_done;

  int vectors;
  int miscompares;

  // Reference model: the pixels of the frame so far, stored by (row, col).
  logic [DW-1:0] img [H][W];
  int            m_row, m_col;
  logic          exp_valid, exp_fd, win_known;
  logic [WB-1:0] exp_win;
  int            valid_cnt, fd_cnt;

  always #5 clk = ~clk;

  window_generator #(
    .DATA_WIDTH (DW),
    .K          (K),
    .IMG_W      (W),
    .IMG_H      (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .win        (win),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  function automatic logic [WB-1:0] pack_win(input int v [9]);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(v[i]);
    return w;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0;
    exp_valid = 1'b0; exp_fd = 1'b0;
    exp_win = '0; win_known = 1'b1;
  endtask

  // Drive one clock cycle and advance the model by what that edge should have done.
  task automatic cycle(input logic c, input logic v, input logic [DW-1:0] d);
    ce = c; in_valid = v; data_in = d;
    @(posedge clk);
    #1;
    if (c) begin
      if (v) begin
        img[m_row][m_col] = d;
        exp_valid = (m_row >= K - 1) && (m_col >= K - 1);
        exp_fd    = (m_row == H - 1) && (m_col == W - 1);
        if (exp_valid) begin
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              exp_win[(i*K+j)*DW +: DW] = img[m_row-K+1+i][m_col-K+1+j];
        end
        win_known = exp_valid;
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row++;
          if (m_row == H) m_row = 0;
        end
      end else begin
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
      end
      if (out_valid === 1'b1) valid_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b1; in_valid = 1'b1; data_in = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    vectors++;
    if (win !== '0) begin miscompares++; $display("FAIL reset_win: got %h want 0", win); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    int w18 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    valid_cnt = 0; fd_cnt = 0;
    for (int p = 0; p < W * H; p++) begin
      cycle(1'b1, 1'b1, DW'(p));
      vectors++;
      if (out_valid !== exp_valid || frame_done !== exp_fd || (win_known && win !== exp_win)) begin
        miscompares++;
        $display("FAIL stream px=%0d: ov=%b/%b fd=%b/%b win=%h want %h", p, out_valid, exp_valid, frame_done, exp_fd, win, exp_win);
      end
      if (p == 18) begin
        vectors++;
        if (out_valid !== 1'b1 || win !== pack_win(w18)) begin
          miscompares++;
          $display("FAIL stream_first_win: ov=%b win=%h want 1 %h", out_valid, win, pack_win(w18));
        end
      end
    end
    cycle(1'b1, 1'b0, 16'h0000);
    vectors++;
    if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL stream_idle_after: ov=%b fd=%b want 0 0", out_valid, frame_done);
    end
    vectors++;
    if (valid_cnt != 24 || fd_cnt != 1) begin
      miscompares++; $display("FAIL stream_counts: valid=%0d fd=%0d want 24 1", valid_cnt, fd_cnt);
    end
  endtask

  task automatic test_gap();
    int w21 [9] = '{3, 4, 5, 11, 12, 13, 19, 20, 21};
    for (int p = 0; p < W * H; p++) begin
      cycle(1'b1, 1'b1, DW'(p));
      vectors++;
      if (out_valid !== exp_valid || frame_done !== exp_fd || (win_known && win !== exp_win)) begin
        miscompares++;
        $display("FAIL gap px=%0d: ov=%b/%b fd=%b/%b win=%h want %h", p, out_valid, exp_valid, frame_done, exp_fd, win, exp_win);
      end
      if (p == 21) begin
        vectors++;
        if (out_valid !== 1'b1 || win !== pack_win(w21)) begin
          miscompares++;
          $display("FAIL gap_resume_win: ov=%b win=%h want 1 %h", out_valid, win, pack_win(w21));
        end
      end
      if (p == 20) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b1, 1'b0, DW'($urandom));
          vectors++;
          if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++; $display("FAIL gap_idle%0d: ov=%b fd=%b want 0 0", g, out_valid, frame_done);
          end
        end
      end
    end
  endtask

  task automatic test_ce_hold();
    valid_cnt = 0; fd_cnt = 0;
    for (int p = 0; p < W * H; p++) begin
      cycle(1'b1, 1'b1, DW'($urandom));
      vectors++;
      if (out_valid !== exp_valid || frame_done !== exp_fd || (win_known && win !== exp_win)) begin
        miscompares++;
        $display("FAIL ce px=%0d: ov=%b/%b fd=%b/%b win=%h want %h", p, out_valid, exp_valid, frame_done, exp_fd, win, exp_win);
      end
      if (p == 20) begin
        for (int g = 0; g < 4; g++) begin
          cycle(1'b0, 1'($urandom), DW'($urandom));
          vectors++;
          if (out_valid !== 1'b1 || win !== exp_win) begin
            miscompares++; $display("FAIL ce_hold%0d: ov=%b win=%h want 1 %h", g, out_valid, win, exp_win);
          end
        end
      end
    end
    vectors++;
    if (valid_cnt != 24 || fd_cnt != 1) begin
      miscompares++; $display("FAIL ce_counts: valid=%0d fd=%0d want 24 1", valid_cnt, fd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int w18 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    for (int p = 0; p <= 30; p++) cycle(1'b1, 1'b1, DW'(p));
    #3 rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || win !== '0) begin
      miscompares++; $display("FAIL reset_mid_async: ov=%b fd=%b win=%h want 0 0 0", out_valid, frame_done, win);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int p = 0; p < W * H; p++) begin
      cycle(1'b1, 1'b1, DW'(p + 100 * (p % 2)));
      vectors++;
      if (out_valid !== exp_valid || frame_done !== exp_fd || (win_known && win !== exp_win)) begin
        miscompares++;
        $display("FAIL reset_mid px=%0d: ov=%b/%b fd=%b/%b win=%h want %h", p, out_valid, exp_valid, frame_done, exp_fd, win, exp_win);
      end
      if (p == 17) begin
        for (int q = 18; q < W * H; q++) begin
          cycle(1'b1, 1'b1, DW'(q));
          if (q == 18) begin
            vectors++;
            if (out_valid !== 1'b1 || win[2*DW +: DW] !== 16'd2 || win[8*DW +: DW] !== 16'd18) begin
              miscompares++; $display("FAIL reset_mid_first_win: ov=%b win=%h", out_valid, win);
            end
          end
        end
        p = W * H;
      end
    end
    for (int p = 0; p < W * H; p++) begin
      cycle(1'b1, 1'b1, DW'(p));
      if (p == 18) begin
        vectors++;
        if (out_valid !== 1'b1 || win !== pack_win(w18)) begin
          miscompares++; $display("FAIL reset_restart_win: ov=%b win=%h want 1 %h", out_valid, win, pack_win(w18));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    valid_cnt = 0; fd_cnt = 0;
    for (int p = 0; p < 2 * W * H; p++) begin
      cycle(1'b1, 1'b1, DW'($urandom));
      vectors++;
      if (out_valid !== exp_valid || frame_done !== exp_fd || (win_known && win !== exp_win)) begin
        miscompares++;
        $display("FAIL b2b px=%0d: ov=%b/%b fd=%b/%b win=%h want %h", p, out_valid, exp_valid, frame_done, exp_fd, win, exp_win);
      end
    end
    vectors++;
    if (valid_cnt != 48 || fd_cnt != 2) begin
      miscompares++; $display("FAIL b2b_counts: valid=%0d fd=%0d want 48 2", valid_cnt, fd_cnt);
    end
  endtask

  task automatic test_random();
    int accepts;
    int budget;
    logic c, v;
    valid_cnt = 0; fd_cnt = 0; accepts = 0; budget = 0;
    while (accepts < 3 * W * H && budget < 3000) begin
      c = ($urandom_range(9, 0) != 0);
      v = ($urandom_range(9, 0) < 7);
      cycle(c, v, DW'($urandom));
      if (c && v) accepts++;
      budget++;
      vectors++;
      if (out_valid !== exp_valid || frame_done !== exp_fd || (win_known && win !== exp_win)) begin
        miscompares++;
        $display("FAIL random cyc=%0d: ov=%b/%b fd=%b/%b win=%h want %h", budget, out_valid, exp_valid, frame_done, exp_fd, win, exp_win);
      end
    end
    vectors++;
    if (accepts < 3 * W * H) begin
      miscompares++; $display("FAIL random_timeout: accepted %0d want %0d", accepts, 3 * W * H);
    end
    vectors++;
    if (valid_cnt != 72 || fd_cnt != 3) begin
      miscompares++; $display("FAIL random_counts: valid=%0d fd=%0d want 72 3", valid_cnt, fd_cnt);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    valid_cnt = 0; fd_cnt = 0;
    model_reset();
    test_reset();
    test_stream();
    test_gap();
    test_ce_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
